icache_refill_ctrl: RTL
=======================

Name: icache_refill_ctrl

Overview:
Sequences one instruction-cache line refill at a time. On a miss it picks the victim way: the lowest-index invalid way if one exists, otherwise a pseudo-random way from an internal 8-bit LFSR. It then requests the line from L2, counts the returned beats into the data array and signals completion. It sits between the cache-bank hit/miss logic and the L2 port.

Parameters:
NUM_WAYS, 4, number of ways per set (power of two, 2..8)
LOG_NUM_WAYS, log2(NUM_WAYS), way index width
LINE_BEATS, 4, L2 data beats per cache line (power of two, >=2)
LOG_BEATS, log2(LINE_BEATS), beat counter width
ADDR_W, 32, miss address width
SEED, 8'h00, LFSR reset value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
miss_req_i  in  1  miss pending, held until miss_gnt_o
miss_addr_i  in  ADDR_W  line address of the miss
way_valid_i  in  NUM_WAYS  valid bits of the indexed set, sampled with miss_req_i
miss_gnt_o  out  1  miss accepted, victim latched
l2_req_o  out  1  L2 line request
l2_addr_o  out  ADDR_W  latched miss address
l2_gnt_i  in  1  L2 accepts request
l2_rvalid_i  in  1  L2 data beat valid
refill_we_o  out  1  write current beat into data array
refill_way_OH_o  out  NUM_WAYS  victim way, one-hot
refill_way_BIN_o  out  LOG_NUM_WAYS  victim way, binary
refill_beat_o  out  LOG_BEATS  index of the beat being written
refill_done_o  out  1  one-cycle pulse, line complete (tag/valid update)
busy_o  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset state: FSM in IDLE, LFSR = SEED, beat counter 0, victim registers 0, address register 0. All outputs are 0 except refill_way_OH_o = 1 (way 0).
- Reset mid-refill: returns to IDLE on the next edge, no done pulse. L2 beats still in flight are ignored.
- LFSR:
  - Update: feedback = NOT(b7 XOR b3 XOR b2 XOR b1); next = {b6..b0, feedback}.
  - Random way = lfsr[LOG_NUM_WAYS:1]; for NUM_WAYS=2 it is lfsr[1].
  - Uses the pre-advance value.
  - Advances exactly once per accepted miss whose victim is random. It does not advance on misses that take an invalid way.
- Victim select (combinational in IDLE): if way_valid_i != all-ones, take the lowest index i with way_valid_i[i]=0; otherwise take the random way.
- FSM states: IDLE, REQ, DATA, DONE.
  - IDLE: miss_gnt_o = miss_req_i (combinational). When miss_req_i=1, latch the address and victim, reset the beat counter, go to REQ.
  - REQ: l2_req_o=1, l2_addr_o held stable. On l2_gnt_i=1, go to DATA. l2_rvalid_i is ignored in REQ; L2 returns data no earlier than the cycle after the grant.
  - DATA:
    - refill_we_o = l2_rvalid_i (combinational); refill_beat_o = counter.
    - Each valid beat increments the counter.
    - A valid beat while counter = LINE_BEATS-1 wraps the counter to 0 and moves to DONE.
    - Gaps between beats are allowed and may be of any length.
  - DONE: refill_done_o=1 for exactly one cycle, then IDLE. miss_gnt_o is 0 here, so back-to-back misses have a minimum of one idle cycle between them.
- Victim outputs hold their latched value from acceptance until the next acceptance.
- Minimum latency from miss_req_i to refill_done_o: 3 + LINE_BEATS cycles when grant and data are immediate.
- miss_req_i while busy_o=1 is not granted.

Test Plan:
- Reset with SEED=0. Issue 5 misses with way_valid_i=4'b1111, immediate grant, 4 back-to-back beats each -> refill_way_BIN_o = 0, 0, 1, 3, 2 (LFSR values 00, 01, 03, 06, 0D); refill_done_o pulses 1 cycle after the 4th beat.
- way_valid_i=4'b1011 -> victim way 2 (OH 4'b0100). A following miss with 4'b1111 -> way 0, showing the LFSR did not advance.
- l2_gnt_i delayed 5 cycles, rvalid pulsing on alternate cycles -> l2_req_o held 6 cycles with a stable l2_addr_o; refill_we_o is high only on rvalid cycles; refill_beat_o steps 0, 1, 2, 3.
- l2_rvalid_i asserted in REQ before the grant -> no refill_we_o, beat counter unchanged.
- rst asserted after 2 beats -> next cycle busy_o=0, no refill_done_o; LFSR back to SEED, so the next random victim is way 0.
- miss_req_i held high across a full refill -> miss_gnt_o high only in IDLE cycles; the second grant comes the cycle after the refill_done_o pulse.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: sequences one I-cache line refill at a time between the
//   bank hit/miss logic and the L2 port; picks the victim way (lowest invalid
//   way, else pseudo-random from an 8-bit LFSR), requests L2 and writes beats.
// Latency: miss accepted in IDLE, L2 request from the next cycle, one beat per
//   valid cycle after grant, done pulse one cycle after the last beat.
// Backpressure: miss_gnt_o only in IDLE; l2_req_o held until l2_gnt_i; beats
//   may arrive with gaps of any length.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   miss_req_i/addr/way_valid   miss request, line address, set valid bits
//   miss_gnt_o                  miss accepted (combinational in IDLE)
//   l2_req_o/l2_addr_o/l2_gnt_i L2 line request handshake
//   l2_rvalid_i                 L2 data beat valid
//   refill_we_o/way/beat        data-array write strobe, victim way, beat index
//   refill_done_o, busy_o       line complete pulse, controller not idle
module icache_refill_ctrl #(
  parameter int          NUM_WAYS     = 4,
  parameter int          LOG_NUM_WAYS = $clog2(NUM_WAYS),
  parameter int          LINE_BEATS   = 4,
  parameter int          LOG_BEATS    = $clog2(LINE_BEATS),
  parameter int          ADDR_W       = 32,
  parameter logic [7:0]  SEED         = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req_i,
  input  logic [ADDR_W-1:0]       miss_addr_i,
  input  logic [NUM_WAYS-1:0]     way_valid_i,
  output logic                    miss_gnt_o,
  output logic                    l2_req_o,
  output logic [ADDR_W-1:0]       l2_addr_o,
  input  logic                    l2_gnt_i,
  input  logic                    l2_rvalid_i,
  output logic                    refill_we_o,
  output logic [NUM_WAYS-1:0]     refill_way_OH_o,
  output logic [LOG_NUM_WAYS-1:0] refill_way_BIN_o,
  output logic [LOG_BEATS-1:0]    refill_beat_o,
  output logic                    refill_done_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [LOG_BEATS-1:0] BEAT_LAST = LOG_BEATS'(LINE_BEATS - 1);
  localparam logic [NUM_WAYS-1:0]  WAY0_OH   = {{(NUM_WAYS-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [7:0]              lfsr_q, lfsr_d;
  logic [LOG_BEATS-1:0]    beat_q, beat_d;
  logic [LOG_NUM_WAYS-1:0] way_q, way_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;

  logic                    inv_found;
  logic [LOG_NUM_WAYS-1:0] inv_way;
  logic [LOG_NUM_WAYS-1:0] rnd_way;
  logic [7:0]              lfsr_next;

  // XNOR feedback keeps the all-zero seed from locking up the LFSR.
  assign lfsr_next = {lfsr_q[6:0], ~(lfsr_q[7] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[1])};
  // Bit 0 is the freshly shifted-in bit; the way index skips it.
  assign rnd_way   = lfsr_q[LOG_NUM_WAYS:1];

  // Lowest-index invalid way of the indexed set.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!way_valid_i[i] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = LOG_NUM_WAYS'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      beat_q  <= '0;
      way_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      beat_q  <= beat_d;
      way_q   <= way_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    beat_d        = beat_q;
    way_d         = way_q;
    addr_d        = addr_q;
    miss_gnt_o    = 1'b0;
    l2_req_o      = 1'b0;
    refill_we_o   = 1'b0;
    refill_done_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        miss_gnt_o = miss_req_i;
        if (miss_req_i) begin
          addr_d  = miss_addr_i;
          beat_d  = '0;
          state_d = S_REQ;
          if (inv_found) begin
            way_d = inv_way;
          end else begin
            // Random victim uses the pre-advance value; LFSR steps only here.
            way_d  = rnd_way;
            lfsr_d = lfsr_next;
          end
        end
      end
      S_REQ: begin
        l2_req_o = 1'b1;
        if (l2_gnt_i) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        refill_we_o = l2_rvalid_i;
        if (l2_rvalid_i) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        refill_done_o = 1'b1;
        state_d       = S_IDLE;
      end
    endcase
  end

  assign l2_addr_o        = addr_q;
  assign refill_way_BIN_o = way_q;
  assign refill_way_OH_o  = WAY0_OH << way_q;
  assign refill_beat_o    = beat_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule
